// File: rtl/seg7_scan_if.sv
// rtl/seg7_scan_if.sv - signal bundle between a 7-segment scan driver and its user
// Purpose: groups the control, pattern and display signals of seg7_scan_mux.
// Ports (master drives / slave drives):
//   en, dim[2:0], colon_en, seg_in0..3[6:0]  : master -> slave (controls, active-low patterns)
//   seg_out[6:0], dp_n, an[3:0], frame_start : slave -> master (display drive, frame pulse)
interface seg7_scan_if;
  logic       en;
  logic [2:0] dim;
  logic       colon_en;
  logic [6:0] seg_in0;
  logic [6:0] seg_in1;
  logic [6:0] seg_in2;
  logic [6:0] seg_in3;
  logic [6:0] seg_out;
  logic       dp_n;
  logic [3:0] an;
  logic       frame_start;

  modport master (
    output en, dim, colon_en, seg_in0, seg_in1, seg_in2, seg_in3,
    input  seg_out, dp_n, an, frame_start
  );

  modport slave (
    input  en, dim, colon_en, seg_in0, seg_in1, seg_in2, seg_in3,
    output seg_out, dp_n, an, frame_start
  );
endinterface

// File: rtl/seg7_scan_mux.sv
// rtl/seg7_scan_mux.sv - 4-digit common-anode 7-segment scan driver
// Purpose: scans four snapshotted active-low patterns onto one segment bus with
// per-slot blanking, PWM brightness and a blinking colon on digit 2.
// Ports:
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   bus.slave  en, dim, colon_en, seg_in0..3 in; seg_out, dp_n, an, frame_start out
module seg7_scan_mux #(
  parameter int SCAN_DIV  = 12500,
  parameter int BLANK_CYC = 250,
  parameter int COLON_DIV = 25000000
) (
  input  logic        clk,
  input  logic        rst_n,
  seg7_scan_if.slave  bus
);

  localparam int SW = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
  localparam int CW = (COLON_DIV > 1) ? $clog2(COLON_DIV) : 1;

  logic [SW-1:0] slot_cnt;
  logic [1:0]    digit;
  logic [2:0]    pwm;
  logic [6:0]    shadow0, shadow1, shadow2, shadow3;
  logic [CW-1:0] colon_cnt;
  logic          colon_on;

  logic       slot_last;
  logic       frame_end;
  logic       lit;
  logic [6:0] cur_seg;

  assign slot_last = (slot_cnt == SW'(SCAN_DIV - 1));
  assign frame_end = slot_last && (digit == 2'd3);
  assign lit       = bus.en && (slot_cnt >= SW'(BLANK_CYC)) && (pwm <= bus.dim);

  always_comb begin
    cur_seg = shadow0;
    case (digit)
      2'd0: cur_seg = shadow0;
      2'd1: cur_seg = shadow1;
      2'd2: cur_seg = shadow2;
      2'd3: cur_seg = shadow3;
      default: cur_seg = shadow0;
    endcase
  end

  // Free-running PWM phase and colon blink timer; both ignore en.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm       <= 3'd0;
      colon_cnt <= '0;
      colon_on  <= 1'b1;
    end else begin
      pwm <= pwm + 3'd1;
      if (colon_cnt == CW'(COLON_DIV - 1)) begin
        colon_cnt <= '0;
        colon_on  <= ~colon_on;
      end else begin
        colon_cnt <= colon_cnt + CW'(1);
      end
    end
  end

  // Scan position and shadows. While disabled the shadows track the inputs,
  // so a restart shows the latest patterns without waiting a frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_cnt <= '0;
      digit    <= 2'd0;
      shadow0  <= 7'h7F;
      shadow1  <= 7'h7F;
      shadow2  <= 7'h7F;
      shadow3  <= 7'h7F;
    end else if (!bus.en) begin
      slot_cnt <= '0;
      digit    <= 2'd0;
      shadow0  <= bus.seg_in0;
      shadow1  <= bus.seg_in1;
      shadow2  <= bus.seg_in2;
      shadow3  <= bus.seg_in3;
    end else begin
      if (slot_last) begin
        slot_cnt <= '0;
        digit    <= digit + 2'd1;
      end else begin
        slot_cnt <= slot_cnt + SW'(1);
      end
      if (frame_end) begin
        shadow0 <= bus.seg_in0;
        shadow1 <= bus.seg_in1;
        shadow2 <= bus.seg_in2;
        shadow3 <= bus.seg_in3;
      end
    end
  end

  // Registered outputs: one cycle behind the scan state above.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_out_r: begin end
      bus.seg_out     <= 7'h7F;
      bus.dp_n        <= 1'b1;
      bus.an          <= 4'hF;
      bus.frame_start <= 1'b0;
    end else begin
      bus.frame_start <= bus.en && frame_end;
      bus.an          <= lit ? ~(4'b0001 << digit) : 4'hF;
      bus.seg_out     <= lit ? cur_seg : 7'h7F;
      bus.dp_n        <= ~(lit && (digit == 2'd2) && bus.colon_en && colon_on);
    end
  end

endmodule

// File: tb/tb_seg7_scan_mux.sv
// tb/tb_seg7_scan_mux.sv - scoreboard testbench for seg7_scan_mux
module tb_seg7_scan_mux;
  localparam int SD = 16;
  localparam int BC = 2;
  localparam int CD = 100;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  seg7_scan_if bus ();

  seg7_scan_mux #(.SCAN_DIV(SD), .BLANK_CYC(BC), .COLON_DIV(CD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  // Expected output word: {an, seg_out, dp_n, frame_start}
  logic [12:0] exp_q[$];

  // Reference model: everything derived from elapsed-cycle counts.
  int         n_cyc;
  int         t_scan;
  logic [6:0] m_shadow[4];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_cyc  = 0;
      t_scan = 0;
      for (int k = 0; k < 4; k++) m_shadow[k] = 7'h7F;
      exp_q.delete();
    end else begin
      int slot, dig, pwm;
      bit colon_on, lit, snap;
      logic [6:0] si[4];
      logic [3:0] e_an;
      logic [6:0] e_seg;
      logic       e_dp, e_fs;
      si[0] = bus.seg_in0; si[1] = bus.seg_in1;
      si[2] = bus.seg_in2; si[3] = bus.seg_in3;
      slot     = t_scan % SD;
      dig      = (t_scan / SD) % 4;
      pwm      = n_cyc % 8;
      colon_on = ((n_cyc / CD) % 2) == 0;
      lit      = bus.en && slot >= BC && pwm <= int'(bus.dim);
      snap     = bus.en && slot == SD - 1 && dig == 3;
      e_an  = 4'hF;
      e_seg = 7'h7F;
      e_dp  = 1'b1;
      if (lit) begin
        e_an[dig] = 1'b0;
        e_seg     = m_shadow[dig];
        e_dp      = !(dig == 2 && bus.colon_en && colon_on);
      end
      e_fs = snap;
      exp_q.push_back({e_an, e_seg, e_dp, e_fs});
      if (!bus.en) begin
        for (int k = 0; k < 4; k++) m_shadow[k] = si[k];
        t_scan = 0;
      end else begin
        if (snap) for (int k = 0; k < 4; k++) m_shadow[k] = si[k];
        t_scan++;
      end
      n_cyc++;
    end
  end

  // Monitor: compare every registered output cycle against the scoreboard.
  always @(negedge clk) begin
    if (rst_n && exp_q.size() > 0) begin
      logic [12:0] e, a;
      e = exp_q.pop_front();
      a = {bus.an, bus.seg_out, bus.dp_n, bus.frame_start};
      n_chk++;
      if (a === e) n_pass++;
      else $display("FAIL scan_out t=%0t got an=%b seg=%h dp_n=%b fs=%b want an=%b seg=%h dp_n=%b fs=%b",
                    $time, a[12:9], a[8:2], a[1], a[0], e[12:9], e[8:2], e[1], e[0]);
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic set_seg(input int k, input logic [6:0] v);
    case (k)
      0: bus.seg_in0 = v;
      1: bus.seg_in1 = v;
      2: bus.seg_in2 = v;
      default: bus.seg_in3 = v;
    endcase
  endtask

  task automatic check_blank(input string name);
    n_chk++;
    if (bus.an === 4'hF && bus.seg_out === 7'h7F && bus.dp_n === 1'b1 && bus.frame_start === 1'b0)
      n_pass++;
    else
      $display("FAIL %s got an=%b seg=%h dp_n=%b fs=%b want an=1111 seg=7f dp_n=1 fs=0",
               name, bus.an, bus.seg_out, bus.dp_n, bus.frame_start);
  endtask

  initial begin
    bus.en = 1'b0;
    bus.dim = 3'd7;
    bus.colon_en = 1'b0;
    bus.seg_in0 = 7'h7F;
    bus.seg_in1 = 7'h7F;
    bus.seg_in2 = 7'h7F;
    bus.seg_in3 = 7'h7F;
    wait_cyc(3);
    check_blank("reset_state");
    rst_n = 1'b1;
    wait_cyc(8);

    // Basic scan with the digits 0..3
    bus.seg_in0 = 7'h40; bus.seg_in1 = 7'h79;
    bus.seg_in2 = 7'h24; bus.seg_in3 = 7'h30;
    bus.en = 1'b1;
    wait_cyc(35);
    bus.seg_in1 = 7'h12;   // during digit 2: must not tear this frame
    wait_cyc(150);

    // Brightness
    bus.dim = 3'd1;
    wait_cyc(130);
    bus.dim = 3'd4;
    wait_cyc(70);

    // Colon
    bus.dim = 3'd7;
    bus.colon_en = 1'b1;
    wait_cyc(450);
    bus.colon_en = 1'b0;
    wait_cyc(70);

    // Enable toggle mid-slot, with a new pattern during the off time
    wait_cyc(7);
    bus.en = 1'b0;
    wait_cyc(1);
    check_blank("en_drop_blank");
    bus.seg_in0 = 7'h19;
    wait_cyc(3);
    bus.en = 1'b1;
    wait_cyc(80);

    // Randomized stimulus
    for (int i = 0; i < 3000; i++) begin
      if (bus.en ? ($urandom_range(199) == 0) : ($urandom_range(19) == 0)) bus.en = ~bus.en;
      if ($urandom_range(99) == 0) bus.dim = 3'($urandom_range(7));
      if ($urandom_range(149) == 0) bus.colon_en = ~bus.colon_en;
      if ($urandom_range(19) == 0) set_seg($urandom_range(3), 7'($urandom_range(127)));
      wait_cyc(1);
    end

    // Asynchronous reset in the middle of a cycle while lit
    bus.en = 1'b1;
    bus.dim = 3'd7;
    bus.colon_en = 1'b1;
    wait_cyc(45);
    #2;
    rst_n = 1'b0;
    #1;
    check_blank("async_reset");
    bus.en = 1'b0;
    wait_cyc(2);
    check_blank("reset_hold");
    rst_n = 1'b1;
    wait_cyc(10);
    check_blank("en0_after_reset");
    bus.en = 1'b1;
    wait_cyc(140);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
